// File: rtl/alex_cfg_sequencer_if.sv
// Command stream from the Alex config sequencer to the serial shifter stage.
interface alex_cfg_sequencer_if;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport master (output m_axis_tdata, output m_axis_tvalid, input m_axis_tready);
  modport slave  (input m_axis_tdata, input m_axis_tvalid, output m_axis_tready);
endinterface

// File: rtl/alex_cfg_sequencer.sv
// Turns the TX/RX Alex board words into 32-bit stream commands, issued on change
// and re-issued on a programmable refresh interval.
module alex_cfg_sequencer #(
  parameter int unsigned CNTR_WIDTH = 32,
  parameter logic [1:0]  TX_LOAD    = 2'b01,
  parameter logic [1:0]  RX_LOAD    = 2'b10
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [15:0]           cfg_tx_data,
  input  logic [15:0]           cfg_rx_data,
  input  logic [CNTR_WIDTH-1:0] cfg_refresh_period,
  alex_cfg_sequencer_if.master  m_axis,
  output logic                  sts_busy
);
  // state | meaning
  // IDLE  | nothing outstanding; launches the next pending channel
  // SEND  | command held on the stream until accepted
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [31:0]           tdata_q, tdata_d;
  logic                  sel_rx_q, sel_rx_d;
  logic                  last_rx_q, last_rx_d;
  logic [15:0]           shadow_tx_q, shadow_tx_d;
  logic [15:0]           shadow_rx_q, shadow_rx_d;
  logic                  force_tx_q, force_tx_d;
  logic                  force_rx_q, force_rx_d;
  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wrap;
  logic                  pend_tx, pend_rx, pick_rx, tvalid;

  assign pend_tx = force_tx_q | (cfg_tx_data != shadow_tx_q);
  assign pend_rx = force_rx_q | (cfg_rx_data != shadow_rx_q);
  // With both pending, serve the channel that did not go last.
  assign pick_rx = pend_rx & (~pend_tx | ~last_rx_q);
  assign tvalid  = (state_q == SEND);

  assign m_axis.m_axis_tvalid = tvalid;
  assign m_axis.m_axis_tdata  = tdata_q;
  assign sts_busy             = tvalid | pend_tx | pend_rx;

  // Compare against period-1 so a shortened period wraps on the very next edge.
  always_comb begin
    wrap  = 1'b0;
    cnt_d = '0;
    if (cfg_refresh_period != '0) begin
      if (cnt_q >= cfg_refresh_period - CNT_ONE) wrap = 1'b1;
      else                                       cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d     = state_q;
    tdata_d     = tdata_q;
    sel_rx_d    = sel_rx_q;
    last_rx_d   = last_rx_q;
    shadow_tx_d = shadow_tx_q;
    shadow_rx_d = shadow_rx_q;
    force_tx_d  = force_tx_q;
    force_rx_d  = force_rx_q;
    case (state_q)
      IDLE: begin
        if (pend_tx | pend_rx) begin
          state_d  = SEND;
          sel_rx_d = pick_rx;
          tdata_d  = pick_rx ? {14'b0, RX_LOAD, cfg_rx_data} : {14'b0, TX_LOAD, cfg_tx_data};
        end
      end
      SEND: begin
        if (m_axis.m_axis_tready) begin
          state_d   = IDLE;
          last_rx_d = sel_rx_q;
          if (sel_rx_q) begin
            shadow_rx_d = tdata_q[15:0];
            force_rx_d  = 1'b0;
          end else begin
            shadow_tx_d = tdata_q[15:0];
            force_tx_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A refresh landing on the handshake edge must still win over the clear.
    if (wrap) begin
      force_tx_d = 1'b1;
      force_rx_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      tdata_q     <= '0;
      sel_rx_q    <= 1'b0;
      last_rx_q   <= 1'b1;
      shadow_tx_q <= '0;
      shadow_rx_q <= '0;
      force_tx_q  <= 1'b1;
      force_rx_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      sel_rx_q    <= sel_rx_d;
      last_rx_q   <= last_rx_d;
      shadow_tx_q <= shadow_tx_d;
      shadow_rx_q <= shadow_rx_d;
      force_tx_q  <= force_tx_d;
      force_rx_q  <= force_rx_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alex_cfg_sequencer.sv
// Bench for alex_cfg_sequencer: directed scenarios plus a random phase, all
// checked every cycle against a transaction-level model of the sequencer.
module tb_alex_cfg_sequencer;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] cfg_tx = 16'h0000;
  logic [15:0] cfg_rx = 16'h0000;
  logic [31:0] period = 32'd0;
  logic        busy;
  int          checks = 0;
  int          failures = 0;

  logic [15:0] vals [4] = '{16'h0001, 16'h0002, 16'hBEEF, 16'h0000};
  logic [31:0] per_tab [4] = '{32'd0, 32'd1, 32'd3, 32'd17};

  alex_cfg_sequencer_if bus();

  alex_cfg_sequencer dut (
    .aclk              (aclk),
    .areset            (areset),
    .cfg_tx_data       (cfg_tx),
    .cfg_rx_data       (cfg_rx),
    .cfg_refresh_period(period),
    .m_axis            (bus),
    .sts_busy          (busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: channel 0 = TX, channel 1 = RX.
  logic [15:0] m_shadow [2];
  bit          m_force [2];
  logic        m_last;
  logic [31:0] m_cnt;
  logic [31:0] m_word;
  bit          m_valid;

  always @(posedge aclk or posedge areset) begin
    bit   wrap;
    bit   p0, p1;
    logic ch;
    if (areset) begin
      m_shadow[0] = 16'h0; m_shadow[1] = 16'h0;
      m_force[0]  = 1'b1;  m_force[1]  = 1'b1;
      m_last      = 1'b1;
      m_cnt       = 32'd0;
      m_word      = 32'd0;
      m_valid     = 1'b0;
    end else begin
      wrap  = (period != 32'd0) && (m_cnt >= period - 32'd1);
      m_cnt = (wrap || period == 32'd0) ? 32'd0 : m_cnt + 32'd1;
      if (m_valid) begin
        if (bus.m_axis_tready) begin
          ch = (m_word[17:16] == 2'b10);
          m_shadow[ch] = m_word[15:0];
          m_force[ch]  = 1'b0;
          m_last       = ch;
          m_valid      = 1'b0;
        end
      end else begin
        p0 = m_force[0] || (cfg_tx != m_shadow[0]);
        p1 = m_force[1] || (cfg_rx != m_shadow[1]);
        if (p0 || p1) begin
          ch      = (p0 && p1) ? ~m_last : p1;
          m_word  = ch ? {14'b0, 2'b10, cfg_rx} : {14'b0, 2'b01, cfg_tx};
          m_valid = 1'b1;
        end
      end
      if (wrap) begin
        m_force[0] = 1'b1;
        m_force[1] = 1'b1;
      end
    end
  end

  always @(negedge aclk) begin
    logic exp_busy;
    exp_busy = m_valid | m_force[0] | m_force[1] | (cfg_tx != m_shadow[0]) | (cfg_rx != m_shadow[1]);
    chk("model_tvalid", 32'(bus.m_axis_tvalid), 32'(m_valid));
    if (m_valid) chk("model_tdata", bus.m_axis_tdata, m_word);
    chk("model_busy", 32'(busy), 32'(exp_busy));
  end

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic wait_cmd(input string name, input logic [31:0] exp, input int exp_wait);
    int n = 0;
    while (!bus.m_axis_tvalid && n < 200) begin
      step();
      n++;
    end
    if (!bus.m_axis_tvalid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_tvalid expected=tvalid within 200 cycles", name);
    end else begin
      chk({name, "_data"}, bus.m_axis_tdata, exp);
      if (exp_wait >= 0) chk({name, "_latency"}, 32'(n), 32'(exp_wait));
    end
  endtask

  task automatic ack(input string name, input int delay);
    repeat (delay) step();
    bus.m_axis_tready = 1'b1;
    step();
    bus.m_axis_tready = 1'b0;
    chk({name, "_drop"}, 32'(bus.m_axis_tvalid), 32'd0);
  endtask

  initial begin
    int issues[$];
    logic pv;
    int  cnt;
    bus.m_axis_tready = 1'b0;
    cfg_tx = 16'h1234;
    cfg_rx = 16'hABCD;
    period = 32'd0;
    areset = 1'b1;
    repeat (3) step();
    areset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rst_tdata", bus.m_axis_tdata, 32'd0);

    wait_cmd("rst_tx", 32'h0001_1234, 1);
    ack("rst_tx", 1);
    wait_cmd("rst_rx", 32'h0002_ABCD, 1);
    ack("rst_rx", 1);
    repeat (3) step();
    chk("settled_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("settled_busy", 32'(busy), 32'd0);

    cfg_tx = 16'h0055;
    wait_cmd("tx55", 32'h0001_0055, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 10) cfg_tx = 16'h00AA;
      chk("hold_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
      chk("hold_tdata", bus.m_axis_tdata, 32'h0001_0055);
    end
    ack("tx55", 0);
    wait_cmd("txAA", 32'h0001_00AA, 1);
    ack("txAA", 1);

    cfg_tx = 16'h0077;
    cfg_rx = 16'h0066;
    wait_cmd("both_rx_first", 32'h0002_0066, 1);
    ack("both_rx_first", 1);
    wait_cmd("both_tx_second", 32'h0001_0077, 1);
    ack("both_tx_second", 1);
    repeat (2) step();

    period = 32'd100;
    pv = 1'b0;
    for (int i = 1; i <= 350; i++) begin
      step();
      if (bus.m_axis_tvalid && !pv) issues.push_back(i);
      pv = bus.m_axis_tvalid;
      bus.m_axis_tready = bus.m_axis_tvalid && !bus.m_axis_tready;
    end
    period = 32'd0;
    bus.m_axis_tready = 1'b0;
    chk("refresh_count", 32'(issues.size()), 32'd6);
    if (issues.size() >= 5) begin
      chk("refresh_first", 32'(issues[0]), 32'd101);
      chk("refresh_gap1", 32'(issues[2] - issues[0]), 32'd100);
      chk("refresh_gap2", 32'(issues[4] - issues[2]), 32'd100);
    end
    repeat (3) step();

    cfg_rx = 16'h0001;
    wait_cmd("rx1", 32'h0002_0001, 1);
    ack("rx1", 1);
    cfg_tx = 16'h0123;
    wait_cmd("tx123", 32'h0001_0123, 1);
    repeat (3) step();
    cfg_rx = 16'h0002;
    repeat (2) step();
    cfg_rx = 16'h0001;
    repeat (2) step();
    ack("tx123", 0);
    cnt = 0;
    repeat (10) begin
      step();
      if (bus.m_axis_tvalid) cnt++;
    end
    chk("no_rx_glitch_cmd", 32'(cnt), 32'd0);
    chk("no_rx_glitch_busy", 32'(busy), 32'd0);

    cfg_tx = 16'h0456;
    wait_cmd("tx456", 32'h0001_0456, 1);
    #1 areset = 1'b1;
    #1 chk("async_rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    step();
    areset = 1'b0;
    wait_cmd("post_rst_tx", 32'h0001_0456, 1);
    ack("post_rst_tx", 1);
    wait_cmd("post_rst_rx", 32'h0002_0001, 1);
    ack("post_rst_rx", 1);

    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 9) == 0) cfg_tx = vals[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0) cfg_rx = vals[$urandom_range(0, 3)];
      if ($urandom_range(0, 199) == 0) period = per_tab[$urandom_range(0, 3)];
      bus.m_axis_tready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #1 areset = 1'b1;
        #1 areset = 1'b0;
      end
    end
    bus.m_axis_tready = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alex_cfg_sequencer.md
Name: alex_cfg_sequencer

Overview:
- Upstream feeder for the Alex serial shifter stage: converts two software-visible 16-bit filter/attenuator configuration words (TX board word and RX board word) into 32-bit AXI-Stream command words.
- Issues a command whenever a word differs from the value last delivered downstream.
- Also re-issues both words on a programmable refresh timer so that a disturbed Alex board is periodically restored.

Parameters:
- CNTR_WIDTH, 32, width of the refresh timer and of cfg_refresh_period.
- TX_LOAD, 2'b01, load field value attached to TX words (drives Alex TX latch strobe).
- RX_LOAD, 2'b10, load field value attached to RX words (drives Alex RX latch strobe).

Ports:
- aclk  in  1  clock; all logic rising-edge.
- areset  in  1  asynchronous, active-high reset.
- cfg_tx_data  in  16  requested TX board word, level, may change any cycle.
- cfg_rx_data  in  16  requested RX board word, level, may change any cycle.
- cfg_refresh_period  in  CNTR_WIDTH  refresh interval in aclk cycles; 0 disables refresh.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  32  [15:0] data, [17:16] load field, [31:18] always 0.
- m_axis_tvalid  out  1  command valid.
- sts_busy  out  1  high while a command is outstanding (m_axis_tvalid) or any send is pending.

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0, m_axis_tdata=0, sts_busy=1 after release, refresh counter=0, shadow_tx=shadow_rx=0. Both force flags are set, so both words are sent once after reset regardless of value.
- Pending per channel: pend_x = force_x | (cfg_x_data != shadow_x).
- FSM has two states, IDLE and SEND.
- IDLE -> SEND when any pend_x is set. Selection:
  - Only one pending: take it.
  - Both pending: take the channel not served last. The last-served bit resets to RX, so TX goes first after reset.
  - On the transition edge, register m_axis_tdata = {14'b0, X_LOAD, cfg_x_data} and set m_axis_tvalid=1. Latency: a change on cfg seen in IDLE gives tvalid on the next edge.
- SEND:
  - tdata and tvalid are held stable until the cycle where m_axis_tvalid && m_axis_tready.
  - On that edge: shadow_x <= sent data (not current cfg), clear force_x, toggle last-served to x, tvalid <= 0, go to IDLE.
  - Minimum one idle cycle between commands. Back-to-back TX then RX gives tvalid low for exactly one cycle.
- cfg change while in SEND: the held word is not modified. After handshake, shadow != cfg, so the channel is pending again and is resent with the new value.
- cfg changes and returns to the shadow value before being sampled in IDLE: no command is issued.
- Refresh timer:
  - Runs while cfg_refresh_period != 0. Counts 0..period-1 and wraps to 0.
  - On wrap, sets force_tx and force_rx.
  - period=1 sets the force flags every cycle.
  - A period change takes effect at once. If counter >= new period, the counter wraps on the next cycle.
  - period=0 holds the counter at 0 and never sets force.
- Simultaneous events:
  - Force set and force clear (handshake) on the same channel in the same cycle: set wins, and the word is resent.
  - Reset mid-SEND: tvalid drops asynchronously. The partially accepted word is not tracked; both words are resent after release.
- Downstream tready is a one-cycle pulse issued one cycle after tvalid is observed while the stage is idle. This block does not rely on tready before tvalid and tolerates tready arriving any number of cycles later.
- sts_busy = m_axis_tvalid | pend_tx | pend_rx (combinational from registers).

Test Plan:
- Reset release with cfg_tx=16'h1234, cfg_rx=16'hABCD, period=0, tready pulses 2 cycles after each tvalid -> tdata 32'h0001_1234 then 32'h0002_ABCD. Then tvalid stays low and sts_busy=0.
- Idle. Change cfg_tx to 16'h0055 -> tvalid next cycle with tdata 32'h0001_0055. Hold tready low 20 cycles -> tdata unchanged and tvalid high throughout.
- During the SEND of 16'h0055, change cfg_tx to 16'h00AA -> after handshake, one idle cycle, then tdata 32'h0001_00AA.
- Both channels changed in the same cycle after last-served=TX -> RX word issued first, TX second.
- period=100, cfg static -> TX/RX pair is reissued every 100 cycles, with the force flag setting on each counter wrap.
- Toggle cfg_rx 16'h0001 -> 16'h0002 -> 16'h0001 within one SEND of TX -> no RX command issued. Also assert areset mid-SEND -> tvalid is 0 immediately, and both words are sent after release.
